hex_scan_driver: RTL and testbench
==================================

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter DWELL, default 50000: clk cycles each digit is driven; legal range is 1 to 2^20-1.
REQ-002 Parameter GAP, default 500: all-off clk cycles after each digit; legal range is 1 to 2^16-1.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 load  in  1  request to capture data/dp_in/blank_in.
REQ-006 data  in  16  four hex nibbles; data[3:0] is digit 0 (rightmost).
REQ-007 dp_in  in  4  decimal point per digit, 1 = lit.
REQ-008 blank_in  in  4  per-digit forced blank, 1 = dark.
REQ-009 ready  out  1  high when a load will be accepted.
REQ-010 an  out  4  digit enables, active-low; an[i] drives digit i.
REQ-011 seg  out  8  active-low segments; seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp.
REQ-012 frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-013 Scan FSM SHALL have states DRIVE and GAP, plus a 2-bit digit index of 0..3 and one dwell counter.
- DRIVE lasts exactly DWELL cycles, then the FSM enters GAP.
- GAP lasts exactly GAP cycles, then the FSM enters DRIVE for index+1; the index wraps 3->0.
REQ-014 All outputs SHALL be registered.
- DRIVE: an = ~(1<<index); seg = decode of the active nibble, with seg[7] = ~dp.
- GAP: an = 4'hF and seg = 8'hFF.
REQ-015 Decode SHALL use the standard hex font 0-F. Example codes for seg[6:0]: 0->7'h40, 8->7'h00, F->7'h0E.
REQ-016 A digit with blank_in set SHALL hold an = 4'hF and seg = 8'hFF for its whole DRIVE slot, and its timing SHALL be unchanged.
REQ-017 Load handshake:
- load && ready captures data/dp_in/blank_in into a pending register.
- ready falls on the next cycle.
- load while ready is low SHALL be ignored.
REQ-018 The pending register SHALL transfer to the active register on the last GAP cycle of digit 3, in the same cycle as frame_tick. ready rises on the following cycle. A displayed frame SHALL never mix old and new data.
REQ-019 When load && ready coincides with the frame-end cycle, the capture SHALL go to pending and SHALL NOT transfer until the next frame end.
REQ-020 One frame SHALL take exactly 4*(DWELL+GAP) cycles. frame_tick SHALL pulse once per frame.

Reset
REQ-021 While rst is high, all state SHALL be set as follows:
- Outputs: an = 4'hF, seg = 8'hFF, ready = 1, frame_tick = 0.
- Internal: index = 0, state = DRIVE, counter = 0; active and pending registers cleared to 0, with no load pending.
REQ-022 On the first rising edge after rst falls, the block SHALL drive digit 0 (an = 4'hE).
REQ-023 Reset asserted mid-frame or with a load pending SHALL discard the pending data. rst SHALL take priority over load.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN:
- Defined: digits 3, 2 and 1 SHALL be blanked per REQ-016 when their nibble and all higher nibbles are zero. Digit 0 is never blanked this way.
- Undefined: only blank_in blanks digits.
- Scan timing SHALL be identical in both builds.

Verification (DWELL=4, GAP=2; frame = 24 cycles)
REQ-025 Reset release with active = 0 -> an sequence: E x4, F x2, D x4, F x2, B x4, F x2, 7 x4, F x2, repeating. seg = 8'hC0 in every DRIVE slot; frame_tick on cycle 24.
REQ-026 load = 1 with data 16'h12AF, dp_in 4'b0001 mid-frame:
- ready low from the next cycle until 1 cycle after frame_tick.
- The current frame still shows 0000.
- The next frame shows digit 0 seg = 8'h0E (F, dp lit), digit 3 seg = 8'hF9 (1).
REQ-027 A second load during ready = 0 with data 16'hFFFF -> ignored; the display shows the first data.
REQ-028 load asserted exactly on the frame_tick cycle -> data is displayed only after the following frame_tick.
REQ-029 rst for 1 cycle mid-DRIVE of digit 2 with a load pending -> an = F and seg = FF during reset, then the frame restarts at digit 0 showing 0000; ready = 1.
REQ-030 LEADING_ZERO_BLANK_EN defined, data 16'h0050 -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0; the same build with data 16'h0000 shows only digit 0 lit.

Source files
------------

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: four-digit multiplexed seven-segment scanner with a double-buffered load handshake.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   load, data, dp_in,       capture request and the payload it captures: four hex nibbles
//   blank_in                 (data[3:0] is digit 0), decimal points (1 = lit), forced blanks (1 = dark)
//   ready                    high when a load will be accepted
//   an[3:0]                  active-low digit enables, an[i] drives digit i
//   seg[7:0]                 active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick               one-cycle pulse at the end of each 4-digit frame
// Parameters: DWELL (1..2^20-1) drive cycles per digit, GAP (1..2^16-1) all-off cycles after each digit.
// Macro LEADING_ZERO_BLANK_EN: when defined, digits 3..1 go dark while they and every higher nibble are zero.
module hex_scan_driver #(
  parameter int DWELL = 50000,
  parameter int GAP = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic        ready,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);
  typedef enum logic {ST_DRIVE, ST_GAP} state_t;
  state_t st, st_n;
  logic [1:0] idx, idx_n;
  logic [19:0] cnt, cnt_n;
  logic [15:0] act_data, pend_data;
  logic [3:0] act_dp, act_bl, pend_dp, pend_bl, blk, nib;
  logic [6:0] font;
  logic last_drive, last_gap, frame_end, lit;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_DRIVE;
      idx <= 2'd0;
      cnt <= 20'd0;
    end else begin
      st <= st_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    last_drive = cnt == 20'(DWELL - 1);
    last_gap = cnt == 20'(GAP - 1);
    frame_end = st == ST_GAP && last_gap && idx == 2'd3;
    st_n = st;
    idx_n = idx;
    cnt_n = cnt + 20'd1;
    if (st == ST_DRIVE && last_drive) begin
      st_n = ST_GAP;
      cnt_n = 20'd0;
    end else if (st == ST_GAP && last_gap) begin
      st_n = ST_DRIVE;
      idx_n = idx + 2'd1;
      cnt_n = 20'd0;
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign blk = act_bl | {act_data[15:12] == 4'h0, act_data[15:8] == 8'h0, act_data[15:4] == 12'h0, 1'b0};
`else
  assign blk = act_bl;
`endif
  assign nib = act_data[{idx, 2'b00} +: 4];
  assign lit = st == ST_DRIVE && !blk[idx];
  always_comb begin
    font = 7'h7F;
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      an <= 4'hF;
      seg <= 8'hFF;
      ready <= 1'b1;
      frame_tick <= 1'b0;
      act_data <= 16'h0;
      act_dp <= 4'h0;
      act_bl <= 4'h0;
      pend_data <= 16'h0;
      pend_dp <= 4'h0;
      pend_bl <= 4'h0;
    end else begin
      an <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg <= lit ? {~act_dp[idx], font} : 8'hFF;
      frame_tick <= frame_end;
      // ready stays low from capture until the cycle after the frame that swapped it in
      ready <= ready ? !load : frame_tick;
      if (load && ready) begin
        pend_data <= data;
        pend_dp <= dp_in;
        pend_bl <= blank_in;
      end
      // swap only data that was already pending before this edge, so a same-edge capture waits a frame
      if (frame_end && !ready) begin
        act_data <= pend_data;
        act_dp <= pend_dp;
        act_bl <= pend_bl;
      end
    end
  end
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: self-checking bench for hex_scan_driver with DWELL=4, GAP=2.
module tb_hex_scan_driver;
  localparam int DW = 4;
  localparam int GP = 2;
  localparam int FL = 4 * (DW + GP);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] blank_in = 4'h0;
  logic ready, frame_tick;
  logic [3:0] an;
  logic [7:0] seg;
  hex_scan_driver #(.DWELL(DW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blank_in(blank_in),
    .ready(ready), .an(an), .seg(seg), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  typedef struct {
    string name;
    logic [15:0] data;
    logic [3:0] dp;
    logic [3:0] blank;
    logic [15:0] an4;
    logic [31:0] seg4;
  } vec_t;
  typedef struct {
    string name;
    logic [3:0] an;
    logic [7:0] seg;
    logic tick;
    logic rdy;
  } exp_t;
  exp_t q[$];
  exp_t mon_e, rs;
  vec_t tbl[7];
  vec_t cur;
  int tests = 0;
  int fails = 0;
  int pos = 0;
  int w = 0;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      tests++;
      if (an !== mon_e.an || seg !== mon_e.seg || frame_tick !== mon_e.tick || ready !== mon_e.rdy) begin
        fails++;
        $display("FAIL %s: got an=%h seg=%h tick=%b ready=%b, want an=%h seg=%h tick=%b ready=%b",
                 mon_e.name, an, seg, frame_tick, ready, mon_e.an, mon_e.seg, mon_e.tick, mon_e.rdy);
      end
    end
  end
  function automatic exp_t model(vec_t v, int p, logic r, string nm);
    exp_t e;
    int d, off;
    d = p / (DW + GP);
    off = p % (DW + GP);
    e.name = nm;
    e.an = off < DW ? v.an4[4*d +: 4] : 4'hF;
    e.seg = off < DW ? v.seg4[8*d +: 8] : 8'hFF;
    e.tick = p == FL - 1;
    e.rdy = r;
    return e;
  endfunction
  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    pos = (pos + 1) % FL;
  endtask
  task automatic fc(input logic r, input string nm);
    cyc(model(cur, pos, r, nm));
  endtask
  initial begin
    tbl[0] = '{"zero", 16'h0000, 4'h0, 4'h0, 16'h7BDE, 32'hC0C0C0C0};
    tbl[1] = '{"h12AF", 16'h12AF, 4'b0001, 4'h0, 16'h7BDE, 32'hF9A4880E};
    tbl[2] = '{"h3456", 16'h3456, 4'b1010, 4'h0, 16'h7BDE, 32'h30991282};
    tbl[3] = '{"h789B_blank2", 16'h789B, 4'h0, 4'b0100, 16'h7FDE, 32'hF8FF9083};
    tbl[4] = '{"hCDE8_alldp", 16'hCDE8, 4'hF, 4'h0, 16'h7BDE, 32'h46210600};
    tbl[5] = '{"h0050", 16'h0050, 4'h0, 4'h0, 16'h7BDE, 32'hC0C092C0};
    tbl[6] = '{"hFFFF_blank30", 16'hFFFF, 4'h0, 4'b1001, 16'hFBDF, 32'hFF8E8EFF};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[0] = '{"zero_lz", 16'h0000, 4'h0, 4'h0, 16'hFFFE, 32'hFFFFFFC0};
    tbl[5] = '{"h0050_lz", 16'h0050, 4'h0, 4'h0, 16'hFFDE, 32'hFFFF92C0};
`endif
    rs = '{"reset", 4'hF, 8'hFF, 1'b0, 1'b1};
    @(posedge clk);
    #1;
    tests++;
    if (an !== 4'hF || seg !== 8'hFF || ready !== 1'b1 || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: an=%h seg=%h ready=%b tick=%b", an, seg, ready, frame_tick);
    end
    cyc(rs);
    cyc(rs);
    rst = 1'b0;
    cyc(rs);
    pos = 0;
    cur = tbl[0];
    repeat (FL) fc(1'b1, "reset_frame");
    for (int i = 1; i < 7; i++) begin
      while (pos != 2) fc(1'b1, "pre_load");
      load = 1'b1;
      data = tbl[i].data;
      dp_in = tbl[i].dp;
      blank_in = tbl[i].blank;
      fc(1'b1, "load_cycle");
      load = 1'b0;
      while (pos != 10) fc(1'b0, {tbl[i].name, "_old_frame"});
      load = 1'b1;
      data = ~tbl[i].data;
      dp_in = ~tbl[i].dp;
      blank_in = 4'h0;
      fc(1'b0, "ignored_load");
      load = 1'b0;
      while (pos != 0) fc(1'b0, {tbl[i].name, "_old_frame"});
      cur = tbl[i];
      repeat (FL) fc(1'b1, tbl[i].name);
    end
    while (pos != FL - 1) fc(1'b1, "pre_tick");
    load = 1'b1;
    data = tbl[1].data;
    dp_in = tbl[1].dp;
    blank_in = tbl[1].blank;
    fc(1'b1, "load_on_tick");
    load = 1'b0;
    repeat (FL) fc(1'b0, "deferred_frame");
    cur = tbl[1];
    repeat (FL) fc(1'b1, "after_deferred");
    while (pos != 2) fc(1'b1, "pre_load_rst");
    load = 1'b1;
    data = tbl[2].data;
    dp_in = tbl[2].dp;
    blank_in = tbl[2].blank;
    fc(1'b1, "load_before_rst");
    load = 1'b0;
    while (pos != 13) fc(1'b0, "pending_frame");
    rst = 1'b1;
    fc(1'b0, "rst_cycle");
    rst = 1'b0;
    cyc('{"rst_outputs", 4'hF, 8'hFF, 1'b0, 1'b1});
    pos = 0;
    cur = tbl[0];
    repeat (2 * FL) fc(1'b1, "post_rst_frame");
    w = 0;
    while (frame_tick !== 1'b1 && w < 2 * FL) begin
      @(posedge clk);
      #1;
      w++;
    end
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL frame_tick_timeout: no frame_tick within %0d cycles", 2 * FL);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
